// File: rtl/piece_sequencer_pkg.sv
// Shared types for the falling-piece game: game state, collision-check opcodes, sequencer FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: game_state_t, chk_op_t and seq_state_t, all in package tetris_pkg.
package tetris_pkg;

  typedef enum logic [1:0] {
    HOME = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } game_state_t;

  typedef enum logic [2:0] {
    OP_SPAWN = 3'd0,
    OP_LEFT  = 3'd1,
    OP_RIGHT = 3'd2,
    OP_ROT   = 3'd3,
    OP_DOWN  = 3'd4
  } chk_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_WAIT,
    S_CHK,
    S_LOCK,
    S_CLEAR,
    S_OVER
  } seq_state_t;

endpackage

// File: rtl/piece_sequencer_gravity_timer.sv
// Gravity time base: counts frame ticks and fires a fall pulse every DROP_TICKS ticks.
// Latency: fall is combinational on the tick that completes a period; the counter updates next edge.
// Backpressure: none; ticks are ignored while en=0, and clr wins over a same-cycle tick.
// Ports: clk, reset (sync, active-high), en (count enable), clr (zero the counter),
//        tick (frame pulse), fall (one-cycle set pulse for the fall flag).
module gravity_timer #(
  parameter int DROP_TICKS = 48,
  parameter int CNT_W      = $clog2(DROP_TICKS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic tick,
  output logic fall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DROP_TICKS - 1);

  logic [CNT_W-1:0] r_cnt;

  // A tick coinciding with clr (spawn commit / leaving play) is discarded.
  assign fall = en && !clr && tick && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (en && tick) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piece_sequencer.sv
// Active-piece sequencer: spawn, player moves, gravity, lock, line-clear hand-off while game state is PLAY.
// Latency: chk_req one cycle after an op is selected; commit one cycle after chk_ack && chk_ok.
// Backpressure: chk_req held until chk_ack; move/gravity requests wait in 1-deep pending flags.
// Ports: clk, reset (sync, active-high), state, tick, mv_left/right/rot/drop in;
//        chk_req/chk_op out, chk_ack/chk_ok in; commit, lock, clear_start out; clear_done in; game_over out.
// Optional: PIECE_SEQUENCER_HARD_DROP_EN enables hard drop on mv_drop (otherwise mv_drop is ignored).
module piece_sequencer #(
  parameter int DROP_TICKS = 48,
  parameter int CNT_W      = $clog2(DROP_TICKS + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] state,
  input  logic       tick,
  input  logic       mv_left,
  input  logic       mv_right,
  input  logic       mv_rot,
  input  logic       mv_drop,
  output logic       chk_req,
  output logic [2:0] chk_op,
  input  logic       chk_ack,
  input  logic       chk_ok,
  output logic       commit,
  output logic       lock,
  output logic       clear_start,
  input  logic       clear_done,
  output logic       game_over
);
  import tetris_pkg::*;

  seq_state_t r_st;
  chk_op_t    r_chk_op;
  logic       r_chk_req;
  logic       r_commit;
  logic       r_lock;
  logic       r_clear_start;
  logic       r_game_over;
  logic       r_pend_left;
  logic       r_pend_right;
  logic       r_pend_rot;
  logic       r_pend_fall;

  logic       w_play;
  logic       w_active;
  logic       w_spawn_ok;
  logic       w_fall;
  logic       w_grav_en;
  logic       w_grav_clr;
  logic       w_down_pend;
  logic       w_op_vld;
  chk_op_t    w_op;

  assign w_play     = (state == PLAY);
  assign w_active   = (r_st == S_SPAWN) || (r_st == S_WAIT) || (r_st == S_CHK);
  assign w_spawn_ok = (r_st == S_SPAWN) && r_chk_req && chk_ack && chk_ok;
  assign w_grav_clr = !w_play || w_spawn_ok;

`ifdef PIECE_SEQUENCER_HARD_DROP_EN
  logic r_pend_drop;
  // A hard drop in progress owns the DOWN slot, so gravity is frozen meanwhile.
  assign w_grav_en   = w_play && w_active && !r_pend_drop;
  assign w_down_pend = r_pend_fall || r_pend_drop;
`else
  logic w_unused;
  assign w_unused    = &{1'b0, mv_drop};
  assign w_grav_en   = w_play && w_active;
  assign w_down_pend = r_pend_fall;
`endif

  gravity_timer #(
    .DROP_TICKS(DROP_TICKS),
    .CNT_W     (CNT_W)
  ) u_gravity (
    .clk  (clk),
    .reset(reset),
    .en   (w_grav_en),
    .clr  (w_grav_clr),
    .tick (tick),
    .fall (w_fall)
  );

  // Next op in priority order: DOWN (drop/gravity) > ROT > LEFT > RIGHT.
  always_comb begin
    w_op_vld = 1'b1;
    w_op     = OP_DOWN;
    if (w_down_pend)       w_op = OP_DOWN;
    else if (r_pend_rot)   w_op = OP_ROT;
    else if (r_pend_left)  w_op = OP_LEFT;
    else if (r_pend_right) w_op = OP_RIGHT;
    else begin
      w_op_vld = 1'b0;
      w_op     = OP_SPAWN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st          <= S_IDLE;
      r_chk_req     <= 1'b0;
      r_chk_op      <= OP_SPAWN;
      r_commit      <= 1'b0;
      r_lock        <= 1'b0;
      r_clear_start <= 1'b0;
      r_game_over   <= 1'b0;
      r_pend_left   <= 1'b0;
      r_pend_right  <= 1'b0;
      r_pend_rot    <= 1'b0;
      r_pend_fall   <= 1'b0;
`ifdef PIECE_SEQUENCER_HARD_DROP_EN
      r_pend_drop   <= 1'b0;
`endif
    end else begin
      r_commit      <= 1'b0;
      r_lock        <= 1'b0;
      r_clear_start <= 1'b0;
      if (!w_play && (r_st != S_OVER)) begin
        // Leaving play abandons the piece; any in-flight ack is simply never sampled.
        r_st         <= S_IDLE;
        r_chk_req    <= 1'b0;
        r_pend_left  <= 1'b0;
        r_pend_right <= 1'b0;
        r_pend_rot   <= 1'b0;
        r_pend_fall  <= 1'b0;
`ifdef PIECE_SEQUENCER_HARD_DROP_EN
        r_pend_drop  <= 1'b0;
`endif
      end else begin
        case (r_st)
          S_IDLE: r_st <= S_SPAWN;
          S_SPAWN: begin
            if (!r_chk_req) begin
              r_chk_req <= 1'b1;
              r_chk_op  <= OP_SPAWN;
            end else if (chk_ack) begin
              r_chk_req <= 1'b0;
              if (chk_ok) begin
                r_commit <= 1'b1;
                r_st     <= S_WAIT;
              end else begin
                r_game_over <= 1'b1;
                r_st        <= S_OVER;
              end
            end
          end
          S_WAIT: begin
            if (w_op_vld) begin
              r_chk_req <= 1'b1;
              r_chk_op  <= w_op;
              r_st      <= S_CHK;
              // The drop flag stays up so DOWN keeps reissuing until it fails.
              case (w_op)
                OP_DOWN:  r_pend_fall  <= 1'b0;
                OP_ROT:   r_pend_rot   <= 1'b0;
                OP_LEFT:  r_pend_left  <= 1'b0;
                OP_RIGHT: r_pend_right <= 1'b0;
                default:  ;
              endcase
            end
          end
          S_CHK: begin
            if (chk_ack) begin
              r_chk_req <= 1'b0;
              if (chk_ok) begin
                r_commit <= 1'b1;
                r_st     <= S_WAIT;
              end else if (r_chk_op == OP_DOWN) begin
                r_lock <= 1'b1;
                r_st   <= S_LOCK;
              end else begin
                r_st <= S_WAIT;
              end
            end
          end
          S_LOCK: begin
            r_clear_start <= 1'b1;
            r_st          <= S_CLEAR;
            r_pend_left   <= 1'b0;
            r_pend_right  <= 1'b0;
            r_pend_rot    <= 1'b0;
            r_pend_fall   <= 1'b0;
`ifdef PIECE_SEQUENCER_HARD_DROP_EN
            r_pend_drop   <= 1'b0;
`endif
          end
          S_CLEAR: if (clear_done) r_st <= S_SPAWN;
          S_OVER:  r_st <= S_OVER;
          default: r_st <= S_IDLE;
        endcase
        // Placed after the issue logic so a new pulse in the issuing cycle re-arms its flag.
        if (w_active) begin
          if (mv_left)  r_pend_left  <= 1'b1;
          if (mv_right) r_pend_right <= 1'b1;
          if (mv_rot)   r_pend_rot   <= 1'b1;
          if (w_fall)   r_pend_fall  <= 1'b1;
`ifdef PIECE_SEQUENCER_HARD_DROP_EN
          if (mv_drop)  r_pend_drop  <= 1'b1;
`endif
        end
      end
    end
  end

  assign chk_req     = r_chk_req;
  assign chk_op      = r_chk_op;
  assign commit      = r_commit;
  assign lock        = r_lock;
  assign clear_start = r_clear_start;
  assign game_over   = r_game_over;

endmodule

// File: tb/tb_piece_sequencer.sv
module tb_piece_sequencer;

  localparam int DT = 4;
  localparam logic [2:0] OPC_SPAWN = 3'd0;
  localparam logic [2:0] OPC_LEFT  = 3'd1;
  localparam logic [2:0] OPC_RIGHT = 3'd2;
  localparam logic [2:0] OPC_ROT   = 3'd3;
  localparam logic [2:0] OPC_DOWN  = 3'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state;
  logic       tick, mv_left, mv_right, mv_rot, mv_drop;
  logic       chk_req;
  logic [2:0] chk_op;
  logic       chk_ack, chk_ok;
  logic       commit, lock, clear_start, clear_done, game_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piece_sequencer #(.DROP_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .state(state), .tick(tick),
    .mv_left(mv_left), .mv_right(mv_right), .mv_rot(mv_rot), .mv_drop(mv_drop),
    .chk_req(chk_req), .chk_op(chk_op), .chk_ack(chk_ack), .chk_ok(chk_ok),
    .commit(commit), .lock(lock), .clear_start(clear_start),
    .clear_done(clear_done), .game_over(game_over)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_req(input int max, output bit got);
    got = chk_req;
    for (int i = 0; i < max && !got; i++) begin
      step();
      got = chk_req;
    end
  endtask

  task automatic give_ack(input bit ok, input bit extra_right);
    chk_ack = 1'b1; chk_ok = ok; mv_right = extra_right;
    step();
    chk_ack = 1'b0; chk_ok = 1'b0; mv_right = 1'b0;
  endtask

  task automatic pulse_tick(input bit l, input bit r, input bit ro);
    tick = 1'b1; mv_left = l; mv_right = r; mv_rot = ro;
    step();
    tick = 1'b0; mv_left = 1'b0; mv_right = 1'b0; mv_rot = 1'b0;
  endtask

  task automatic pulse_move(input bit l, input bit r, input bit ro);
    mv_left = l; mv_right = r; mv_rot = ro;
    step();
    mv_left = 1'b0; mv_right = 1'b0; mv_rot = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    checks++;
    if ({chk_req, commit, lock, clear_start, game_over} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b expected=00000", {chk_req, commit, lock, clear_start, game_over});
    end
    reset = 1'b0;
    idle(2);
    checks++;
    if (chk_req !== 1'b0) begin
      errors++; $display("FAIL idle_no_req got=%b expected=0", chk_req);
    end
  endtask

  task automatic test_spawn();
    state = 2'b01;
    step();
    checks++;
    if (chk_req !== 1'b0) begin
      errors++; $display("FAIL spawn_req_early got=%b expected=0", chk_req);
    end
    step();
    checks++;
    if (chk_req !== 1'b1 || chk_op !== OPC_SPAWN) begin
      errors++; $display("FAIL spawn_req got req=%b op=%0d expected req=1 op=%0d", chk_req, chk_op, OPC_SPAWN);
    end
    step();
    give_ack(1'b1, 1'b0);
    checks++;
    if (commit !== 1'b1 || chk_req !== 1'b0) begin
      errors++; $display("FAIL spawn_commit got commit=%b req=%b expected 1 0", commit, chk_req);
    end
    step();
    checks++;
    if (commit !== 1'b0 || game_over !== 1'b0 || chk_req !== 1'b0) begin
      errors++; $display("FAIL spawn_after got commit=%b go=%b req=%b expected 0 0 0", commit, game_over, chk_req);
    end
  endtask

  task automatic test_gravity();
    bit got;
    for (int i = 0; i < DT - 1; i++) begin
      pulse_tick(1'b0, 1'b0, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(2);
    checks++;
    if (chk_req !== 1'b0) begin
      errors++; $display("FAIL grav_early got req=%b expected=0", chk_req);
    end
    pulse_tick(1'b0, 1'b0, 1'b0);
    wait_req(4, got);
    checks++;
    if (!got || chk_op !== OPC_DOWN) begin
      errors++; $display("FAIL grav_down got req=%b op=%0d expected req=1 op=%0d", got, chk_op, OPC_DOWN);
    end
    idle($urandom_range(0, 3));
    give_ack(1'b1, 1'b0);
    checks++;
    if (commit !== 1'b1) begin
      errors++; $display("FAIL grav_commit got=%b expected=1", commit);
    end
    for (int i = 0; i < DT; i++) begin
      pulse_tick(1'b0, 1'b0, 1'b0);
      idle($urandom_range(0, 2));
    end
    wait_req(4, got);
    checks++;
    if (!got || chk_op !== OPC_DOWN) begin
      errors++; $display("FAIL grav_down2 got req=%b op=%0d expected req=1 op=%0d", got, chk_op, OPC_DOWN);
    end
    give_ack(1'b0, 1'b0);
    checks++;
    if (lock !== 1'b1 || commit !== 1'b0 || chk_req !== 1'b0) begin
      errors++; $display("FAIL grav_lock got lock=%b commit=%b req=%b expected 1 0 0", lock, commit, chk_req);
    end
    step();
    checks++;
    if (lock !== 1'b0 || clear_start !== 1'b1) begin
      errors++; $display("FAIL grav_clear_start got lock=%b cs=%b expected 0 1", lock, clear_start);
    end
    step();
    checks++;
    if (clear_start !== 1'b0 || chk_req !== 1'b0) begin
      errors++; $display("FAIL grav_clear_wait got cs=%b req=%b expected 0 0", clear_start, chk_req);
    end
    idle($urandom_range(0, 3));
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    wait_req(4, got);
    checks++;
    if (!got || chk_op !== OPC_SPAWN) begin
      errors++; $display("FAIL grav_respawn got req=%b op=%0d expected req=1 op=%0d", got, chk_op, OPC_SPAWN);
    end
    give_ack(1'b1, 1'b0);
    checks++;
    if (commit !== 1'b1) begin
      errors++; $display("FAIL grav_respawn_commit got=%b expected=1", commit);
    end
  endtask

  // Reference: the 4th tick raises a DOWN request; afterwards the pending moves
  // are served rot, left, right; a failed move commits nothing.
  task automatic test_priority();
    bit got, l, r, ro, extra, ok;
    logic [2:0] exp_op;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        l = 1'b1; r = 1'b0; ro = 1'b1; extra = 1'b0;
      end else begin
        l = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
        ro = 1'($urandom_range(0, 1)); extra = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < DT - 1; i++) begin
        pulse_tick(1'b0, 1'b0, 1'b0);
        idle($urandom_range(0, 2));
      end
      pulse_tick(l, r, ro);
      wait_req(4, got);
      checks++;
      if (!got || chk_op !== OPC_DOWN) begin
        errors++; $display("FAIL prio_down it=%0d got req=%b op=%0d expected op=%0d", it, got, chk_op, OPC_DOWN);
      end
      idle($urandom_range(0, 2));
      give_ack(1'b1, extra);
      r = r | extra;
      while (l || r || ro) begin
        if (ro) begin exp_op = OPC_ROT; ro = 1'b0; end
        else if (l) begin exp_op = OPC_LEFT; l = 1'b0; end
        else begin exp_op = OPC_RIGHT; r = 1'b0; end
        wait_req(4, got);
        checks++;
        if (!got || chk_op !== exp_op) begin
          errors++; $display("FAIL prio_op it=%0d got req=%b op=%0d expected op=%0d", it, got, chk_op, exp_op);
        end
        ok = (it == 0 && exp_op == OPC_LEFT) ? 1'b0 : 1'($urandom_range(0, 1));
        idle($urandom_range(0, 2));
        give_ack(ok, 1'b0);
        checks++;
        if (commit !== ok || chk_req !== 1'b0) begin
          errors++; $display("FAIL prio_commit it=%0d op=%0d got commit=%b req=%b expected commit=%b req=0", it, exp_op, commit, chk_req, ok);
        end
      end
      idle(3);
      checks++;
      if (chk_req !== 1'b0) begin
        errors++; $display("FAIL prio_drain it=%0d got req=%b expected=0", it, chk_req);
      end
    end
  endtask

  task automatic test_absorb();
    bit got;
    pulse_move(1'b0, 1'b0, 1'b1);
    wait_req(4, got);
    checks++;
    if (!got || chk_op !== OPC_ROT) begin
      errors++; $display("FAIL absorb_rot got req=%b op=%0d expected op=%0d", got, chk_op, OPC_ROT);
    end
    pulse_move(1'b1, 1'b0, 1'b0);
    step();
    pulse_move(1'b1, 1'b0, 1'b0);
    give_ack(1'b1, 1'b0);
    wait_req(4, got);
    checks++;
    if (!got || chk_op !== OPC_LEFT) begin
      errors++; $display("FAIL absorb_left got req=%b op=%0d expected op=%0d", got, chk_op, OPC_LEFT);
    end
    give_ack(1'b1, 1'b0);
    idle(4);
    checks++;
    if (chk_req !== 1'b0) begin
      errors++; $display("FAIL absorb_single got req=%b expected=0", chk_req);
    end
  endtask

  task automatic test_abort();
    bit got;
    pulse_move(1'b0, 1'b0, 1'b1);
    wait_req(4, got);
    pulse_move(1'b1, 1'b0, 1'b0);
    state = 2'b00;
    step();
    checks++;
    if (chk_req !== 1'b0) begin
      errors++; $display("FAIL abort_drop_req got=%b expected=0", chk_req);
    end
    idle(2);
    chk_ack = 1'b1; chk_ok = 1'b1;
    step();
    chk_ack = 1'b0; chk_ok = 1'b0;
    checks++;
    if (commit !== 1'b0) begin
      errors++; $display("FAIL abort_late_ack got commit=%b expected=0", commit);
    end
    state = 2'b01;
    idle(2);
    checks++;
    if (chk_req !== 1'b1 || chk_op !== OPC_SPAWN) begin
      errors++; $display("FAIL abort_respawn got req=%b op=%0d expected req=1 op=%0d", chk_req, chk_op, OPC_SPAWN);
    end
    give_ack(1'b1, 1'b0);
    idle(4);
    checks++;
    if (chk_req !== 1'b0) begin
      errors++; $display("FAIL abort_flags_cleared got req=%b expected=0", chk_req);
    end
  endtask

  task automatic test_spawn_fail();
    bit got, seen;
    state = 2'b00;
    step();
    state = 2'b01;
    wait_req(4, got);
    give_ack(1'b0, 1'b0);
    checks++;
    if (game_over !== 1'b1 || commit !== 1'b0 || chk_req !== 1'b0) begin
      errors++; $display("FAIL over_set got go=%b commit=%b req=%b expected 1 0 0", game_over, commit, chk_req);
    end
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) state = 2'b10;
      tick = 1'($urandom_range(0, 1)); mv_left = 1'($urandom_range(0, 1));
      mv_rot = 1'($urandom_range(0, 1)); mv_drop = 1'($urandom_range(0, 1));
      step();
      if (chk_req) seen = 1'b1;
    end
    tick = 1'b0; mv_left = 1'b0; mv_rot = 1'b0; mv_drop = 1'b0;
    checks++;
    if (seen !== 1'b0 || game_over !== 1'b1) begin
      errors++; $display("FAIL over_hold got req_seen=%b go=%b expected 0 1", seen, game_over);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (game_over !== 1'b0 || chk_req !== 1'b0) begin
      errors++; $display("FAIL over_reset got go=%b req=%b expected 0 0", game_over, chk_req);
    end
  endtask

  task automatic test_drop();
    bit got;
    state = 2'b01;
    wait_req(6, got);
    give_ack(1'b1, 1'b0);
    idle(2);
    mv_drop = 1'b1;
    step();
    mv_drop = 1'b0;
`ifdef PIECE_SEQUENCER_HARD_DROP_EN
    begin
      int ncommit;
      bit oks [4];
      oks = '{1'b1, 1'b1, 1'b1, 1'b0};
      ncommit = 0;
      for (int i = 0; i < 4; i++) begin
        wait_req(4, got);
        checks++;
        if (!got || chk_op !== OPC_DOWN) begin
          errors++; $display("FAIL drop_down i=%0d got req=%b op=%0d expected op=%0d", i, got, chk_op, OPC_DOWN);
        end
        give_ack(oks[i], 1'b0);
        if (commit) ncommit++;
      end
      checks++;
      if (ncommit != 3 || lock !== 1'b1) begin
        errors++; $display("FAIL drop_lock got commits=%0d lock=%b expected 3 1", ncommit, lock);
      end
    end
`else
    wait_req(8, got);
    checks++;
    if (got !== 1'b0) begin
      errors++; $display("FAIL drop_ignored got req=%b expected=0", got);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; state = 2'b00; tick = 1'b0;
    mv_left = 1'b0; mv_right = 1'b0; mv_rot = 1'b0; mv_drop = 1'b0;
    chk_ack = 1'b0; chk_ok = 1'b0; clear_done = 1'b0;
    test_reset();
    test_spawn();
    test_gravity();
    test_priority();
    test_absorb();
    test_abort();
    test_spawn_fail();
    test_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
